bus_mem_if: RTL and testbench

- Consumer end of the shared 16-bit CPU bus. Captures bus values into MAR and MDR on load strobes.
- Runs single-word SRAM read/write transactions from those registers, with a fixed number of wait states.
- Returns read data into MDR, which the bus driver gates back onto the bus.
- Sits between the datapath bus and the external SRAM pins. It is controlled by the ISDU state machine.

---
 rtl/lc3_pkg.sv | 14 +
 rtl/bus_mem_if_if.sv | 37 +++
 rtl/ld_reg16.sv | 26 ++
 rtl/bus_mem_if.sv | 102 ++++++++++
 tb/tb_bus_mem_if.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 style datapath memory interface.
// Holds the memory FSM state encoding and the datapath word width.
package lc3_pkg;

  localparam int WORD_W       = 16;
  localparam int DEFAULT_WAIT = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

endpackage

// File: rtl/bus_mem_if_if.sv
// Datapath bus, ISDU control and SRAM pin bundle for the memory interface block.
// The slave modport is the memory interface; master is the datapath/ISDU/SRAM side.
interface bus_mem_if_if
  import lc3_pkg::*;
#(
  parameter int ADDR_W = 16
) ();

  logic [WORD_W-1:0] Bus;
  logic              LD_MAR;
  logic              LD_MDR;
  logic              MemReq;
  logic              MemWrite;
  logic [ADDR_W-1:0] MAR;
  logic [WORD_W-1:0] MDR;
  logic              Ready;
  logic              Done;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [WORD_W-1:0] Mem_WData;
  logic [WORD_W-1:0] Mem_RData;
  logic              Mem_CE_n;
  logic              Mem_OE_n;
  logic              Mem_WE_n;

  modport slave (
    input  Bus, LD_MAR, LD_MDR, MemReq, MemWrite, Mem_RData,
    output MAR, MDR, Ready, Done, Mem_Addr, Mem_WData,
           Mem_CE_n, Mem_OE_n, Mem_WE_n
  );

  modport master (
    output Bus, LD_MAR, LD_MDR, MemReq, MemWrite, Mem_RData,
    input  MAR, MDR, Ready, Done, Mem_Addr, Mem_WData,
           Mem_CE_n, Mem_OE_n, Mem_WE_n
  );

endinterface

// File: rtl/ld_reg16.sv
// Load-enabled register with asynchronous active-low clear; holds when ld_i is low.
module ld_reg16
  import lc3_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (ld_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/bus_mem_if.sv
// Bus consumer owning MAR/MDR and running single-word SRAM accesses with fixed wait states.
// SRAM strobes decode from registered state only, so input activity cannot glitch them.
module bus_mem_if
  import lc3_pkg::*;
#(
  parameter int WAIT_CYCLES = DEFAULT_WAIT,
  parameter int ADDR_W      = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  bus_mem_if_if.slave   bus
);

  localparam logic [3:0] WAIT_M1 = 4'(WAIT_CYCLES - 1);

  mem_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              op_q, op_d;

  logic              mar_ld;
  logic              mdr_ld;
  logic [WORD_W-1:0] mdr_d;
  logic [ADDR_W-1:0] mar;
  logic [WORD_W-1:0] mdr;

  ld_reg16 #(.W(ADDR_W)) u_mar (
    .clk_i  (Clk),
    .rst_ni (Reset),
    .ld_i   (mar_ld),
    .d_i    (ADDR_W'(bus.Bus)),
    .q_o    (mar)
  );

  ld_reg16 #(.W(WORD_W)) u_mdr (
    .clk_i  (Clk),
    .rst_ni (Reset),
    .ld_i   (mdr_ld),
    .d_i    (mdr_d),
    .q_o    (mdr)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    mar_ld  = 1'b0;
    mdr_ld  = 1'b0;
    mdr_d   = bus.Bus;
    unique case (state_q)
      IDLE: begin
        mar_ld = bus.LD_MAR;
        mdr_ld = bus.LD_MDR;
        if (bus.MemReq) begin
          op_d    = bus.MemWrite;
          cnt_d   = WAIT_M1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          // Read data takes the MDR mux on the final access edge, overriding any bus load.
          if (!op_q) begin
            mdr_ld = 1'b1;
            mdr_d  = bus.Mem_RData;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.MAR       = mar;
  assign bus.MDR       = mdr;
  assign bus.Mem_Addr  = mar;
  assign bus.Mem_WData = mdr;
  assign bus.Ready     = (state_q == IDLE);
  assign bus.Done      = (state_q == DONE);
  assign bus.Mem_CE_n  = (state_q != ACCESS);
  assign bus.Mem_OE_n  = !((state_q == ACCESS) && !op_q);
  assign bus.Mem_WE_n  = !((state_q == ACCESS) && op_q);

endmodule

// File: tb/tb_bus_mem_if.sv
// Self-checking bench for bus_mem_if: directed scenarios plus randomized transactions
// compared against a per-transaction model of MAR/MDR and the expected strobe timeline.
module tb_bus_mem_if;
  import lc3_pkg::*;

  localparam int WAIT = 2;
  localparam int AW   = 16;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  bus_mem_if_if #(.ADDR_W(AW)) bus ();

  bus_mem_if #(.WAIT_CYCLES(WAIT), .ADDR_W(AW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] mar_m;
  logic [15:0] mdr_m;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.LD_MAR   = 1'b0;
    bus.LD_MDR   = 1'b0;
    bus.MemReq   = 1'b0;
    bus.MemWrite = 1'b0;
  endtask

  task automatic load(input bit lm, input bit ld, input logic [15:0] v);
    bus.Bus    = v;
    bus.LD_MAR = lm;
    bus.LD_MDR = ld;
    if (lm) mar_m = v;
    if (ld) mdr_m = v;
    step();
    bus.LD_MAR = 1'b0;
    bus.LD_MDR = 1'b0;
    checks++;
    if (bus.MAR !== mar_m || bus.MDR !== mdr_m) begin
      failures++;
      $display("FAIL load: MAR=%h MDR=%h expected MAR=%h MDR=%h", bus.MAR, bus.MDR, mar_m, mdr_m);
    end
  endtask

  // One full transaction from the request cycle through the first IDLE cycle.
  task automatic run_txn(input bit wr, input logic [15:0] rd, input bit lm, input bit ld,
                         input logic [15:0] v, input bit noise, input bit hold);
    checks++;
    if (bus.Ready !== 1'b1) begin
      failures++;
      $display("FAIL txn_ready_at_req: Ready=%b expected 1", bus.Ready);
    end
    bus.Mem_RData = rd;
    bus.Bus       = v;
    bus.LD_MAR    = lm;
    bus.LD_MDR    = ld;
    bus.MemReq    = 1'b1;
    bus.MemWrite  = wr;
    if (lm) mar_m = v;
    if (ld) mdr_m = v;
    step();
    for (int c = 0; c < WAIT; c++) begin
      checks++;
      if (bus.Ready !== 1'b0 || bus.Done !== 1'b0) begin
        failures++;
        $display("FAIL access_flags c%0d: Ready=%b Done=%b expected 0 0", c, bus.Ready, bus.Done);
      end
      checks++;
      if ({bus.Mem_CE_n, bus.Mem_OE_n, bus.Mem_WE_n} !== {1'b0, wr, ~wr}) begin
        failures++;
        $display("FAIL access_strobes c%0d: CE_n/OE_n/WE_n=%b%b%b expected %b%b%b",
                 c, bus.Mem_CE_n, bus.Mem_OE_n, bus.Mem_WE_n, 1'b0, wr, ~wr);
      end
      checks++;
      if (bus.Mem_Addr !== mar_m || bus.Mem_WData !== mdr_m || bus.MAR !== mar_m) begin
        failures++;
        $display("FAIL access_addr_data c%0d: Addr=%h WData=%h expected %h %h",
                 c, bus.Mem_Addr, bus.Mem_WData, mar_m, mdr_m);
      end
      if (noise) begin
        bus.Bus      = 16'($urandom);
        bus.LD_MAR   = 1'($urandom_range(0, 1));
        bus.LD_MDR   = 1'($urandom_range(0, 1));
        bus.MemWrite = 1'($urandom_range(0, 1));
        bus.MemReq   = hold | 1'($urandom_range(0, 1));
      end else begin
        bus.LD_MAR = 1'b0;
        bus.LD_MDR = 1'b0;
        bus.MemReq = hold;
      end
      step();
    end
    if (!wr) mdr_m = rd;
    checks++;
    if (bus.Done !== 1'b1 || bus.Ready !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: Done=%b Ready=%b expected 1 0", bus.Done, bus.Ready);
    end
    checks++;
    if ({bus.Mem_CE_n, bus.Mem_OE_n, bus.Mem_WE_n} !== 3'b111) begin
      failures++;
      $display("FAIL done_strobes: %b%b%b expected 111", bus.Mem_CE_n, bus.Mem_OE_n, bus.Mem_WE_n);
    end
    checks++;
    if (bus.MDR !== mdr_m || bus.MAR !== mar_m) begin
      failures++;
      $display("FAIL done_regs: MAR=%h MDR=%h expected %h %h", bus.MAR, bus.MDR, mar_m, mdr_m);
    end
    bus.LD_MAR = 1'b0;
    bus.LD_MDR = 1'b0;
    bus.MemReq = hold;
    step();
    checks++;
    if (bus.Ready !== 1'b1 || bus.Done !== 1'b0 || bus.Mem_CE_n !== 1'b1) begin
      failures++;
      $display("FAIL back_to_idle: Ready=%b Done=%b CE_n=%b expected 1 0 1", bus.Ready, bus.Done, bus.Mem_CE_n);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.Bus       = 16'($urandom);
      bus.Mem_RData = 16'($urandom);
      bus.LD_MAR    = 1'($urandom_range(0, 1));
      bus.LD_MDR    = 1'($urandom_range(0, 1));
      bus.MemReq    = 1'($urandom_range(0, 1));
      bus.MemWrite  = 1'($urandom_range(0, 1));
      step();
      checks++;
      if (bus.MAR !== '0 || bus.MDR !== 16'h0 || bus.Ready !== 1'b1 || bus.Done !== 1'b0) begin
        failures++;
        $display("FAIL reset_regs: MAR=%h MDR=%h Ready=%b Done=%b expected 0 0 1 0",
                 bus.MAR, bus.MDR, bus.Ready, bus.Done);
      end
      checks++;
      if ({bus.Mem_CE_n, bus.Mem_OE_n, bus.Mem_WE_n} !== 3'b111) begin
        failures++;
        $display("FAIL reset_strobes: %b%b%b expected 111", bus.Mem_CE_n, bus.Mem_OE_n, bus.Mem_WE_n);
      end
    end
    quiet_inputs();
    mar_m = 16'h0;
    mdr_m = 16'h0;
    Reset = 1'b1;
    step();
  endtask

  task automatic test_write();
    load(1'b1, 1'b0, 16'h3000);
    load(1'b0, 1'b1, 16'hBEEF);
    run_txn(1'b1, 16'($urandom), 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_read();
    load(1'b1, 1'b0, 16'h1234);
    run_txn(1'b0, 16'hCAFE, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    checks++;
    if (bus.MDR !== 16'hCAFE) begin
      failures++;
      $display("FAIL read_mdr: MDR=%h expected CAFE", bus.MDR);
    end
  endtask

  task automatic test_same_cycle();
    run_txn(1'b0, 16'($urandom), 1'b1, 1'b0, 16'h00FF, 1'b0, 1'b0);
    run_txn(1'b1, 16'($urandom), 1'b1, 1'b1, 16'h5A5A, 1'b0, 1'b0);
  endtask

  task automatic test_busy_ignore();
    load(1'b1, 1'b1, 16'h4444);
    run_txn(1'b1, 16'($urandom), 1'b0, 1'b0, 16'hAAAA, 1'b1, 1'b0);
    run_txn(1'b0, 16'h7E57, 1'b0, 1'b0, 16'hAAAA, 1'b1, 1'b0);
    step();
    checks++;
    if (bus.Ready !== 1'b1 || bus.Done !== 1'b0 || bus.Mem_CE_n !== 1'b1) begin
      failures++;
      $display("FAIL busy_no_second_txn: Ready=%b Done=%b CE_n=%b expected 1 0 1",
               bus.Ready, bus.Done, bus.Mem_CE_n);
    end
  endtask

  task automatic test_reset_mid();
    load(1'b1, 1'b1, 16'h2222);
    bus.Mem_RData = 16'h9999;
    bus.MemReq    = 1'b1;
    bus.MemWrite  = 1'b0;
    step();
    bus.MemReq = 1'b0;
    step();
    checks++;
    if (bus.Mem_OE_n !== 1'b0) begin
      failures++;
      $display("FAIL mid_pre_reset_oe: OE_n=%b expected 0", bus.Mem_OE_n);
    end
    Reset = 1'b0;
    #1;
    mar_m = 16'h0;
    mdr_m = 16'h0;
    checks++;
    if ({bus.Mem_CE_n, bus.Mem_OE_n, bus.Mem_WE_n} !== 3'b111 || bus.MDR !== 16'h0 || bus.MAR !== '0) begin
      failures++;
      $display("FAIL mid_reset_abort: strobes=%b%b%b MDR=%h MAR=%h expected 111 0 0",
               bus.Mem_CE_n, bus.Mem_OE_n, bus.Mem_WE_n, bus.MDR, bus.MAR);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.Done !== 1'b0 || bus.MDR !== 16'h0) begin
        failures++;
        $display("FAIL mid_reset_no_done: Done=%b MDR=%h expected 0 0", bus.Done, bus.MDR);
      end
    end
    Reset = 1'b1;
    step();
    load(1'b1, 1'b0, 16'h0777);
    run_txn(1'b0, 16'h4321, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 16'($urandom), 1'b1, 1'b1, 16'h6000, 1'b0, 1'b1);
    run_txn(1'b0, 16'h1111, 1'b0, 1'b0, 16'($urandom), 1'b1, 1'b1);
    run_txn(1'b1, 16'($urandom), 1'b0, 1'b0, 16'($urandom), 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_txn(1'($urandom_range(0, 1)), 16'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
              1'($urandom_range(0, 1)), (i != 29) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
  endtask

  initial begin
    bus.Bus       = '0;
    bus.Mem_RData = '0;
    quiet_inputs();
    mar_m = 16'h0;
    mdr_m = 16'h0;
    test_reset();
    test_write();
    test_read();
    test_same_cycle();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
